// File: rtl/video_timing_ctrl.sv
// 480p60-style scan timing generator: issues pixel fetch coordinates PIPE_LAT
// cycles ahead of the matching hsync/vsync/de so fetched RGB lines up with de.
module video_timing_ctrl #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter bit          SYNC_ACTIVE = 1'b0,
    parameter int unsigned PIPE_LAT    = 2
) (
    input  logic        clk_pixel,
    input  logic        rst,
    input  logic        enable,
    output logic        req_valid,
    output logic [9:0]  req_x,
    output logic [9:0]  req_y,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        frame_start,
    output logic        running,
    output logic [15:0] frame_cnt
);

    localparam int unsigned CW       = 10;
    localparam int unsigned EW       = CW + 1;
    localparam int unsigned TW       = 4;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    // Range bounds carry one extra bit so a total of 1024 cannot alias to 0.
    localparam logic [EW-1:0] H_ACT_E  = EW'(H_ACTIVE);
    localparam logic [EW-1:0] V_ACT_E  = EW'(V_ACTIVE);
    localparam logic [EW-1:0] HS_START = EW'(H_ACTIVE + H_FP);
    localparam logic [EW-1:0] HS_END   = EW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [EW-1:0] VS_START = EW'(V_ACTIVE + V_FP);
    localparam logic [EW-1:0] VS_END   = EW'(V_ACTIVE + V_FP + V_SYNC);

    // Tap order: {hsync, vsync, de, frame_start}
    localparam logic [TW-1:0] IDLE_TAP = {~SYNC_ACTIVE, ~SYNC_ACTIVE, 1'b0, 1'b0};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   h_cnt;
    logic [CW-1:0]   v_cnt;
    logic            h_last;
    logic            v_last;
    logic            frame_last;

    assign h_last     = (h_cnt == H_LAST);
    assign v_last     = (v_cnt == V_LAST);
    assign frame_last = h_last && v_last;

    // Scan FSM and counters; a stop only takes effect on the last pixel of a frame.
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            state     <= IDLE;
            h_cnt     <= '0;
            v_cnt     <= '0;
            frame_cnt <= '0;
            running   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    h_cnt <= '0;
                    v_cnt <= '0;
                    if (enable) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN, DRAIN: begin
                    h_cnt <= h_last ? '0 : h_cnt + CW'(1);
                    if (h_last) begin
                        v_cnt <= v_last ? '0 : v_cnt + CW'(1);
                    end
                    if (frame_last) begin
                        frame_cnt <= frame_cnt + 16'd1;
                    end
                    if (enable) begin
                        state <= RUN;
                    end else if (frame_last) begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end else begin
                        state <= DRAIN;
                    end
                end
                default: begin
                    state   <= IDLE;
                    h_cnt   <= '0;
                    v_cnt   <= '0;
                    running <= 1'b0;
                end
            endcase
        end
    end

    logic [EW-1:0]  h_ext;
    logic [EW-1:0]  v_ext;
    logic           scanning;
    logic           active;
    logic           hs_raw;
    logic           vs_raw;
    logic           fs_raw;
    logic [TW-1:0]  tap_in;
    logic [TW-1:0]  tap_out;

    assign h_ext    = {1'b0, h_cnt};
    assign v_ext    = {1'b0, v_cnt};
    assign scanning = (state != IDLE);

    // Request stage, decoded straight from the counters.
    always_comb begin
        active    = 1'b0;
        hs_raw    = ~SYNC_ACTIVE;
        vs_raw    = ~SYNC_ACTIVE;
        fs_raw    = 1'b0;
        req_valid = 1'b0;
        req_x     = '0;
        req_y     = '0;
        if (scanning) begin
            active = (h_ext < H_ACT_E) && (v_ext < V_ACT_E);
            if ((h_ext >= HS_START) && (h_ext < HS_END)) begin
                hs_raw = SYNC_ACTIVE;
            end
            if ((v_ext >= VS_START) && (v_ext < VS_END)) begin
                vs_raw = SYNC_ACTIVE;
            end
            fs_raw = active && (h_cnt == '0) && (v_cnt == '0);
        end
        if (active) begin
            req_valid = 1'b1;
            req_x     = h_cnt;
            req_y     = v_cnt;
        end
    end

    assign tap_in = {hs_raw, vs_raw, active, fs_raw};

    generate
        if (PIPE_LAT == 0) begin : g_no_pipe
            assign tap_out = tap_in;
        end else begin : g_pipe
            logic [TW-1:0] pipe [PIPE_LAT];

            // Delay chain; reset flushes it so no stale de survives.
            always_ff @(posedge clk_pixel) begin
                if (rst) begin
                    for (int i = 0; i < PIPE_LAT; i++) begin
                        pipe[i] <= IDLE_TAP;
                    end
                end else begin
                    pipe[0] <= tap_in;
                    for (int i = 1; i < PIPE_LAT; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign tap_out = pipe[PIPE_LAT-1];
        end
    endgenerate

    assign hsync       = tap_out[3];
    assign vsync       = tap_out[2];
    assign de          = tap_out[1];
    assign frame_start = tap_out[0];

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Randomized bench for video_timing_ctrl at a reduced raster, checked against
// a frame-position reference model.
module tb_video_timing_ctrl;

    localparam int unsigned HA = 8;
    localparam int unsigned HF = 2;
    localparam int unsigned HS = 3;
    localparam int unsigned HB = 3;
    localparam int unsigned VA = 4;
    localparam int unsigned VF = 1;
    localparam int unsigned VS = 2;
    localparam int unsigned VB = 2;
    localparam bit          SA = 1'b0;
    localparam int unsigned PL = 2;
    localparam int          HT = HA + HF + HS + HB;
    localparam int          VT = VA + VF + VS + VB;
    localparam int          FRAME = HT * VT;

    logic        clk_pixel;
    logic        rst;
    logic        enable;
    logic        req_valid;
    logic [9:0]  req_x;
    logic [9:0]  req_y;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        frame_start;
    logic        running;
    logic [15:0] frame_cnt;

    video_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_ACTIVE(SA), .PIPE_LAT(PL)
    ) dut (
        .clk_pixel   (clk_pixel),
        .rst         (rst),
        .enable      (enable),
        .req_valid   (req_valid),
        .req_x       (req_x),
        .req_y       (req_y),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .frame_start (frame_start),
        .running     (running),
        .frame_cnt   (frame_cnt)
    );

    initial clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // Reference: is the raster running, and where in the frame are we.
    bit          m_run;
    int          m_pos;
    logic [15:0] m_frames;
    logic [3:0]  m_q[$];

    // {hsync, vsync, de, frame_start} as the raster position implies.
    function automatic logic [3:0] look(input bit run, input int pos);
        int  h = pos % HT;
        int  v = pos / HT;
        bit  act = run && (h < HA) && (v < VA);
        bit  hs  = run && (h >= HA + HF) && (h < HA + HF + HS);
        bit  vs  = run && (v >= VA + VF) && (v < VA + VF + VS);
        return {hs ? SA : ~SA, vs ? SA : ~SA, act, act && (pos == 0)};
    endfunction

    task automatic model_edge(input bit r, input bit en);
        if (r) begin
            m_run    = 1'b0;
            m_pos    = 0;
            m_frames = '0;
            m_q.delete();
            for (int i = 0; i <= PL; i++) m_q.push_back(look(1'b0, 0));
        end else begin
            if (!m_run) begin
                m_run = en;
                m_pos = 0;
            end else if (m_pos == FRAME - 1) begin
                m_pos    = 0;
                m_frames = m_frames + 16'd1;
                if (!en) m_run = 1'b0;
            end else begin
                m_pos++;
            end
            m_q.push_back(look(m_run, m_pos));
            if (m_q.size() > PL + 1) void'(m_q.pop_front());
        end
    endtask

    task automatic compare_all();
        logic [3:0] now_t = look(m_run, m_pos);
        logic [3:0] dly_t = m_q[0];
        check("req_valid",   32'(req_valid),   32'(now_t[1]));
        check("req_x",       32'(req_x),       now_t[1] ? 32'(m_pos % HT) : 32'd0);
        check("req_y",       32'(req_y),       now_t[1] ? 32'(m_pos / HT) : 32'd0);
        check("hsync",       32'(hsync),       32'(dly_t[3]));
        check("vsync",       32'(vsync),       32'(dly_t[2]));
        check("de",          32'(de),          32'(dly_t[1]));
        check("frame_start", 32'(frame_start), 32'(dly_t[0]));
        check("running",     32'(running),     32'(m_run));
        check("frame_cnt",   32'(frame_cnt),   32'(m_frames));
    endtask

    task automatic cycle();
        @(posedge clk_pixel);
        model_edge(rst, enable);
        #1;
        compare_all();
    endtask

    // Advance until the model reaches a running frame position, bounded.
    task automatic wait_pos(input int target);
        for (int i = 0; i < 3 * FRAME && !(m_run && m_pos == target); i++) cycle();
        check("wait_pos", 32'(m_pos), 32'(target));
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;

        // Two full frames from start
        repeat (2 * FRAME + 7) cycle();

        // Stop requested early in the frame: frame completes, then idles
        wait_pos(1 * HT);
        enable = 1'b0;
        repeat (FRAME + 40) cycle();
        check("idle_after_stop", 32'(running), 32'd0);

        // Restart, then re-enable while draining
        enable = 1'b1;
        wait_pos(1 * HT + 3);
        enable = 1'b0;
        wait_pos(3 * HT);
        enable = 1'b1;
        repeat (2 * FRAME) cycle();

        // Stop coincident with the last pixel
        wait_pos(FRAME - 1);
        enable = 1'b0;
        cycle();
        check("stop_on_last", 32'(running), 32'd0);
        repeat (20) cycle();

        // Reset mid-frame flushes the delay line
        enable = 1'b1;
        wait_pos(2 * HT + 5);
        rst = 1'b1;
        cycle();
        rst    = 1'b0;
        enable = 1'b0;
        repeat (10) cycle();
        enable = 1'b1;

        // Random enable toggling with occasional reset
        for (int i = 0; i < 12000; i++) begin
            if ($urandom_range(0, 99) < 2) enable = ~enable;
            rst = ($urandom_range(0, 999) == 0);
            cycle();
        end
        rst = 1'b0;
        enable = 1'b1;
        repeat (FRAME) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
